// File: rtl/arm_pkg.sv
// Shared encodings for the ARM execute stage: ALU commands, shift types,
// NZCV bit positions and operand forwarding selects.
package arm_pkg;

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_MVN = 4'b1001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000
    } exe_cmd_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_stage_val2_gen.sv
// Combinational second-operand generator: memory offset, rotated 8-bit
// immediate, or Rm shifted by a 5-bit immediate amount.
module val2_gen
    import arm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] val_rm,
    input  logic [11:0]       shift_operand,
    input  logic              imm,
    input  logic              mem_op,
    output logic [DATA_W-1:0] val2
);

    // A left shift by DATA_W yields zero, so amount 0 needs no special case.
    function automatic logic [DATA_W-1:0] ror_w(input logic [DATA_W-1:0] x,
                                                input logic [4:0] n);
        return (x >> n) | (x << (DATA_W - int'(n)));
    endfunction

    logic [DATA_W-1:0] imm_ext;
    logic [4:0]        rot_amt;
    logic [4:0]        sh_amt;

    always_comb begin
        imm_ext = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
        rot_amt = {shift_operand[11:8], 1'b0};
        sh_amt  = shift_operand[11:7];
        val2    = '0;
        if (mem_op) begin
            val2 = {{(DATA_W-12){1'b0}}, shift_operand};
        end else if (imm) begin
            val2 = ror_w(imm_ext, rot_amt);
        end else begin
            case (shift_operand[6:5])
                SH_LSL:  val2 = val_rm << sh_amt;
                SH_LSR:  val2 = val_rm >> sh_amt;
                SH_ASR:  val2 = $unsigned($signed(val_rm) >>> sh_amt);
                default: val2 = ror_w(val_rm, sh_amt);
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// ARM pipeline execute stage: operand select, Val2, ALU, NZCV register and
// the EXE/MEM pipeline register. Define FORWARDING_EN to enable operand forwarding.
module exe_stage
    import arm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic              imm_in,
    input  logic              c_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [DATA_W-1:0] mem_fwd_val,
    input  logic [DATA_W-1:0] wb_fwd_val,
    output logic [3:0]        status_out,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [DEST_W-1:0] dest_out
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] op_rn;
    logic [DATA_W-1:0] op_rm;
    logic [DATA_W-1:0] val2;

`ifdef FORWARDING_EN
    always_comb begin
        case (sel_src1)
            FWD_MEM: op_rn = mem_fwd_val;
            FWD_WB:  op_rn = wb_fwd_val;
            default: op_rn = val_rn_in;
        endcase
        case (sel_src2)
            FWD_MEM: op_rm = mem_fwd_val;
            FWD_WB:  op_rm = wb_fwd_val;
            default: op_rm = val_rm_in;
        endcase
    end
`else
    // Forwarding ports stay on the boundary so integration is build-independent.
    logic unused_fwd;
    assign unused_fwd = ^{sel_src1, sel_src2, mem_fwd_val, wb_fwd_val};
    assign op_rn = val_rn_in;
    assign op_rm = val_rm_in;
`endif

    val2_gen #(.DATA_W(DATA_W)) u_val2_gen (
        .val_rm        (op_rm),
        .shift_operand (shift_operand_in),
        .imm           (imm_in),
        .mem_op        (mem_r_en_in | mem_w_en_in),
        .val2          (val2)
    );

    logic [DATA_W:0]   alu_wide;
    logic [DATA_W-1:0] alu_res;
    logic              flag_c;
    logic              flag_v;
    logic [3:0]        nzcv;

    logic [3:0]        status_d, status_q;

    // Bit DATA_W of alu_wide is carry-out for adds and borrow for subtracts.
    always_comb begin
        alu_wide = '0;
        flag_c   = status_q[FLAG_C];
        flag_v   = status_q[FLAG_V];
        case (exe_cmd_in)
            CMD_MOV: alu_wide = {1'b0, val2};
            CMD_MVN: alu_wide = {1'b0, ~val2};
            CMD_ADD, CMD_ADC: begin
                alu_wide = {1'b0, op_rn} + {1'b0, val2}
                         + {{DATA_W{1'b0}}, (exe_cmd_in == CMD_ADC) & c_in};
                flag_c   = alu_wide[DATA_W];
                flag_v   = (op_rn[MSB] == val2[MSB]) && (alu_wide[MSB] != op_rn[MSB]);
            end
            CMD_SUB, CMD_SBC: begin
                alu_wide = {1'b0, op_rn} - {1'b0, val2}
                         - {{DATA_W{1'b0}}, (exe_cmd_in == CMD_SBC) & ~c_in};
                flag_c   = ~alu_wide[DATA_W];
                flag_v   = (op_rn[MSB] != val2[MSB]) && (alu_wide[MSB] != op_rn[MSB]);
            end
            CMD_AND: alu_wide = {1'b0, op_rn & val2};
            CMD_ORR: alu_wide = {1'b0, op_rn | val2};
            CMD_EOR: alu_wide = {1'b0, op_rn ^ val2};
            default: alu_wide = '0;
        endcase
        alu_res = alu_wide[MSB:0];
        nzcv    = {alu_res[MSB], (alu_res == '0), flag_c, flag_v};
    end

    always_comb begin
        branch_taken = b_in;
        branch_addr  = pc_in + ({{(DATA_W-24){signed_imm_24_in[23]}}, signed_imm_24_in} << 2);
    end

    logic              wb_en_d, wb_en_q;
    logic              mem_r_en_d, mem_r_en_q;
    logic              mem_w_en_d, mem_w_en_q;
    logic [DATA_W-1:0] alu_res_d, alu_res_q;
    logic [DATA_W-1:0] val_rm_d, val_rm_q;
    logic [DEST_W-1:0] dest_d, dest_q;

    // A flag-setting instruction seen under freeze is replayed later, so it is dropped here.
    always_comb begin
        status_d   = status_q;
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        mem_w_en_d = mem_w_en_q;
        alu_res_d  = alu_res_q;
        val_rm_d   = val_rm_q;
        dest_d     = dest_q;
        if (!freeze) begin
            if (s_in) begin
                status_d = nzcv;
            end
            wb_en_d    = wb_en_in;
            mem_r_en_d = mem_r_en_in;
            mem_w_en_d = mem_w_en_in;
            alu_res_d  = alu_res;
            val_rm_d   = op_rm;
            dest_d     = dest_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q   <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            alu_res_q  <= '0;
            val_rm_q   <= '0;
            dest_q     <= '0;
        end else begin
            status_q   <= status_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            alu_res_q  <= alu_res_d;
            val_rm_q   <= val_rm_d;
            dest_q     <= dest_d;
        end
    end

    assign status_out   = status_q;
    assign wb_en_out    = wb_en_q;
    assign mem_r_en_out = mem_r_en_q;
    assign mem_w_en_out = mem_w_en_q;
    assign alu_res_out  = alu_res_q;
    assign val_rm_out   = val_rm_q;
    assign dest_out     = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed cases plus randomized instructions checked
// every cycle against an arithmetic model of the execute stage.
module tb_exe_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic [31:0] pc_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, c_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] val_rn_in, val_rm_in;
  logic [3:0]  dest_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] mem_fwd_val, wb_fwd_val;
  logic [3:0]  status_out;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [31:0] alu_res_out, val_rm_out;
  logic [3:0]  dest_out;

  int n_checks = 0;
  int n_fail   = 0;

  // model of the registered state
  logic [31:0] exp_q[$];
  logic [2:0]  m_ctl;
  logic [31:0] m_rm;
  logic [3:0]  m_dest;
  logic [3:0]  m_status;

  exe_stage #(.DATA_W(32), .DEST_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .freeze           (freeze),
    .pc_in            (pc_in),
    .wb_en_in         (wb_en_in),
    .mem_r_en_in      (mem_r_en_in),
    .mem_w_en_in      (mem_w_en_in),
    .b_in             (b_in),
    .s_in             (s_in),
    .imm_in           (imm_in),
    .c_in             (c_in),
    .exe_cmd_in       (exe_cmd_in),
    .val_rn_in        (val_rn_in),
    .val_rm_in        (val_rm_in),
    .dest_in          (dest_in),
    .shift_operand_in (shift_operand_in),
    .signed_imm_24_in (signed_imm_24_in),
    .sel_src1         (sel_src1),
    .sel_src2         (sel_src2),
    .mem_fwd_val      (mem_fwd_val),
    .wb_fwd_val       (wb_fwd_val),
    .status_out       (status_out),
    .branch_taken     (branch_taken),
    .branch_addr      (branch_addr),
    .wb_en_out        (wb_en_out),
    .mem_r_en_out     (mem_r_en_out),
    .mem_w_en_out     (mem_w_en_out),
    .alu_res_out      (alu_res_out),
    .val_rm_out       (val_rm_out),
    .dest_out         (dest_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] m_val2(input logic [31:0] rm, input logic [11:0] so,
                                         input logic imm, input logic mem_op);
    int amt;
    int s;
    if (mem_op) return {20'b0, so};
    if (imm) return ror32({24'b0, so[7:0]}, 2 * int'(so[11:8]));
    amt = int'(so[11:7]);
    s = rm;
    case (so[6:5])
      2'd0:    return rm << amt;
      2'd1:    return rm >> amt;
      2'd2:    return s >>> amt;
      default: return ror32(rm, amt);
    endcase
  endfunction

  function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] rn, v2,
                                input logic cin, input logic [3:0] st,
                                output logic [31:0] res, output logic [3:0] nzcv);
    longint unsigned u;
    longint s;
    longint k;
    int srn, sv2;
    logic c, v;
    c = st[1];
    v = st[0];
    srn = rn;
    sv2 = v2;
    res = 32'd0;
    case (cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd2, 4'd3: begin
        k = (cmd == 4'd3) ? longint'(cin) : 0;
        u = longint'({32'b0, rn}) + longint'({32'b0, v2}) + k;
        res = u[31:0];
        c = (u >= 64'h1_0000_0000);
        s = longint'(srn) + longint'(sv2) + k;
        v = (s != longint'(int'(res)));
      end
      4'd4, 4'd5: begin
        k = (cmd == 4'd5) ? longint'(!cin) : 0;
        res = rn - v2 - 32'(k);
        c = (longint'({32'b0, rn}) >= longint'({32'b0, v2}) + k);
        s = longint'(srn) - longint'(sv2) - k;
        v = (s != longint'(int'(res)));
      end
      4'd6: res = rn & v2;
      4'd7: res = rn | v2;
      4'd8: res = rn ^ v2;
      default: res = 32'd0;
    endcase
    nzcv = {res[31], res == 32'd0, c, v};
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // scoreboard check of registered outputs
  task automatic check_regs();
    chk("alu_res_out", alu_res_out, exp_q[$]);
    chk("status_out", status_out, m_status);
    chk("ctl_out", {wb_en_out, mem_r_en_out, mem_w_en_out}, m_ctl);
    chk("val_rm_out", val_rm_out, m_rm);
    chk("dest_out", dest_out, m_dest);
  endtask

  task automatic model_reset();
    m_ctl = 3'b000;
    m_rm = 32'd0;
    m_dest = 4'd0;
    m_status = 4'd0;
    exp_q.push_back(32'd0);
  endtask

  // driver tasks
  task automatic drive(input logic [3:0] cmd, input logic [31:0] rn, rm,
                       input logic [11:0] so, input logic imm, s, frz);
    exe_cmd_in = cmd;
    val_rn_in = rn;
    val_rm_in = rm;
    shift_operand_in = so;
    imm_in = imm;
    s_in = s;
    freeze = frz;
  endtask

  task automatic drive_random();
    exe_cmd_in = 4'($urandom_range(0, 15));
    val_rn_in = pick_val();
    val_rm_in = pick_val();
    shift_operand_in = 12'($urandom);
    imm_in = 1'($urandom_range(0, 1));
    s_in = 1'($urandom_range(0, 1));
    c_in = 1'($urandom_range(0, 1));
    mem_r_en_in = ($urandom_range(0, 5) == 0);
    mem_w_en_in = ($urandom_range(0, 5) == 0);
    wb_en_in = 1'($urandom_range(0, 1));
    b_in = 1'($urandom_range(0, 1));
    freeze = ($urandom_range(0, 5) == 0);
    pc_in = $urandom;
    signed_imm_24_in = 24'($urandom);
    dest_in = 4'($urandom_range(0, 15));
    sel_src1 = 2'($urandom_range(0, 3));
    sel_src2 = 2'($urandom_range(0, 3));
    mem_fwd_val = pick_val();
    wb_fwd_val = pick_val();
  endtask

  // one cycle: check combinational outputs, clock, then check registered state
  task automatic step();
    logic [31:0] rn, rm, v2, res, exp_addr;
    logic [3:0]  nz;
    int off;
    #1;
    chk("branch_taken", 32'(branch_taken), 32'(b_in));
    off = int'(signed_imm_24_in);
    if (off >= 2 ** 23) off -= 2 ** 24;
    exp_addr = pc_in + 32'(off * 4);
    chk("branch_addr", branch_addr, exp_addr);
    rn = val_rn_in;
    rm = val_rm_in;
`ifdef FORWARDING_EN
    if (sel_src1 == 2'd1) rn = mem_fwd_val;
    else if (sel_src1 == 2'd2) rn = wb_fwd_val;
    if (sel_src2 == 2'd1) rm = mem_fwd_val;
    else if (sel_src2 == 2'd2) rm = wb_fwd_val;
`endif
    v2 = m_val2(rm, shift_operand_in, imm_in, mem_r_en_in | mem_w_en_in);
    m_alu(exe_cmd_in, rn, v2, c_in, m_status, res, nz);
    @(posedge clk);
    #1;
    if (!freeze) begin
      m_ctl = {wb_en_in, mem_r_en_in, mem_w_en_in};
      m_rm = rm;
      m_dest = dest_in;
      exp_q.push_back(res);
      if (s_in) m_status = nz;
    end
    check_regs();
  endtask

  initial begin
    rst = 1'b1;
    freeze = 1'b0;
    pc_in = 32'd0;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    b_in = 1'b0; s_in = 1'b0; imm_in = 1'b0; c_in = 1'b0;
    exe_cmd_in = 4'd0;
    val_rn_in = 32'd0; val_rm_in = 32'd0;
    dest_in = 4'd0;
    shift_operand_in = 12'd0;
    signed_imm_24_in = 24'd0;
    sel_src1 = 2'd0; sel_src2 = 2'd0;
    mem_fwd_val = 32'd0; wb_fwd_val = 32'd0;
    model_reset();
    #12;
    check_regs();
    @(negedge clk);
    rst = 1'b0;

    // ADD immediate
    wb_en_in = 1'b1;
    dest_in = 4'd3;
    drive(4'b0010, 32'd5, 32'd0, 12'h003, 1'b1, 1'b1, 1'b0);
    step();
    chk("t1_add_res", alu_res_out, 32'd8);
    chk("t1_add_nzcv", status_out, 32'h0);

    // SUB with signed overflow
    drive(4'b0100, 32'h8000_0000, 32'd0, 12'h001, 1'b1, 1'b1, 1'b0);
    step();
    chk("t2_sub_res", alu_res_out, 32'h7FFF_FFFF);
    chk("t2_sub_nzcv", status_out, 32'h3);

    // shifts through MOV
    drive(4'b0001, 32'd0, 32'h8000_0001, 12'h0C0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t3_asr", alu_res_out, 32'hC000_0000);
    drive(4'b0001, 32'd0, 32'h8000_0001, 12'h0E0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t3_ror", alu_res_out, 32'hC000_0000);
    drive(4'b0001, 32'd0, 32'd0, 12'h4FF, 1'b1, 1'b0, 1'b0);
    step();
    chk("t3_imm_rot", alu_res_out, 32'hFF00_0000);

    // freeze holds result and flags, release updates
    drive(4'b0010, 32'd1, 32'd0, 12'h001, 1'b1, 1'b1, 1'b1);
    step();
    chk("t4_frz_res", alu_res_out, 32'hFF00_0000);
    chk("t4_frz_nzcv", status_out, 32'h3);
    freeze = 1'b0;
    step();
    chk("t4_rel_res", alu_res_out, 32'd2);
    chk("t4_rel_nzcv", status_out, 32'h0);

    // ADD wrap-around
    drive(4'b0010, 32'h7FFF_FFFF, 32'd0, 12'h001, 1'b1, 1'b1, 1'b0);
    step();
    chk("t_wrap_res", alu_res_out, 32'h8000_0000);
    chk("t_wrap_nzcv", status_out, 32'h9);

    // branch target
    pc_in = 32'h100;
    signed_imm_24_in = 24'hFFFFFE;
    b_in = 1'b1;
    #1;
    chk("t5_branch_taken", 32'(branch_taken), 32'd1);
    chk("t5_branch_addr", branch_addr, 32'hF8);
    step();
    b_in = 1'b0;

`ifdef FORWARDING_EN
    sel_src1 = 2'd1;
    mem_fwd_val = 32'd10;
    drive(4'b0010, 32'd99, 32'd0, 12'h001, 1'b1, 1'b0, 1'b0);
    step();
    chk("t6_fwd_res", alu_res_out, 32'd11);
    sel_src1 = 2'd0;
`endif

    for (int i = 0; i < 600; i++) begin
      drive_random();
      step();
    end

    // asynchronous reset between edges
    drive(4'b0010, 32'd7, 32'd9, 12'h001, 1'b1, 1'b1, 1'b0);
    wb_en_in = 1'b1;
    dest_in = 4'd5;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_res", alu_res_out, 32'd0);
    chk("t6_rst_nzcv", status_out, 32'd0);
    chk("t6_rst_ctl", {wb_en_out, mem_r_en_out, mem_w_en_out}, 32'd0);
    chk("t6_rst_rm", val_rm_out, 32'd0);
    chk("t6_rst_dest", dest_out, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0111, 32'h0F0, 32'd0, 12'h00F, 1'b1, 1'b1, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
